// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding load/store engine between the ALU/register file and a
//   32-bit byte-addressed data memory with a req/ack handshake.
//   Ports:
//     clk, reset (async, active low)
//     enable, op_valid, op_load, op_size, op_unsigned, op_addr, op_wdata : core op
//     op_ready, stall                                  : core flow control
//     res_valid, res_rdata, res_error                  : completion / write-back
//     mem_req, mem_we, mem_addr, mem_wdata, mem_be     : memory request
//     mem_ack, mem_rdata                               : memory response
//   TIMEOUT: REQ cycles without ack before an error abort (0 = never).
module load_store_unit #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        op_valid,
   input  logic        op_load,
   input  logic [1:0]  op_size,
   input  logic        op_unsigned,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   output logic        op_ready,
   output logic        stall,
   output logic        res_valid,
   output logic [31:0] res_rdata,
   output logic        res_error,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TLAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] tcnt;
   logic          ld_q, uns_q;
   logic [1:0]    size_q, off_q;

   logic          accept, bad_op, timeout_hit;
   logic [3:0]    be_c;
   logic [31:0]   wdata_c, sh, ld_ext;

   assign accept   = (state == IDLE) & op_valid & enable;
   assign op_ready = (state == IDLE);
   assign stall    = accept | (state == REQ);

   // Misaligned or illegal ops complete with an error and never touch memory.
   assign bad_op = (op_size == 2'd3) |
                   ((op_size == 2'd1) & op_addr[0]) |
                   ((op_size == 2'd2) & (op_addr[1:0] != 2'b00));

   // Final unacked cycle of the window; an ack in this same cycle still wins.
   assign timeout_hit = (TIMEOUT > 0) && (tcnt == TLAST);

   // Byte enables and lane-replicated store data for the incoming op.
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = op_wdata;
      case (op_size)
         2'd0: begin
            be_c    = 4'b0001 << op_addr[1:0];
            wdata_c = {4{op_wdata[7:0]}};
         end
         2'd1: begin
            be_c    = op_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{op_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Move the addressed lane down to bit 0, then extend.
   assign sh = mem_rdata >> {off_q, 3'b000};
   always_comb begin
      ld_ext = mem_rdata;
      case (size_q)
         2'd0:    ld_ext = {{24{~uns_q & sh[7]}},  sh[7:0]};
         2'd1:    ld_ext = {{16{~uns_q & sh[15]}}, sh[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = bad_op ? RESP : REQ;
         REQ:     if (mem_ack || timeout_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         res_valid <= 1'b0;
         res_rdata <= '0;
         res_error <= 1'b0;
         tcnt      <= '0;
         ld_q      <= 1'b0;
         uns_q     <= 1'b0;
         size_q    <= '0;
         off_q     <= '0;
      end else begin
         res_valid <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               ld_q   <= op_load;
               uns_q  <= op_unsigned;
               size_q <= op_size;
               off_q  <= op_addr[1:0];
               tcnt   <= '0;
               if (bad_op) begin
                  res_valid <= 1'b1;
                  res_error <= 1'b1;
                  res_rdata <= '0;
               end else begin
                  mem_req   <= 1'b1;
                  mem_we    <= ~op_load;
                  mem_addr  <= {op_addr[31:2], 2'b00};
                  mem_be    <= be_c;
                  mem_wdata <= wdata_c;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  res_valid <= 1'b1;
                  res_error <= 1'b0;
                  if (ld_q) res_rdata <= ld_ext;
               end else if (timeout_hit) begin
                  mem_req   <= 1'b0;
                  res_valid <= 1'b1;
                  res_error <= 1'b1;
                  res_rdata <= '0;
               end else begin
                  tcnt <= tcnt + CW'(1);
               end
            end
            RESP:    res_error <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: reset state, a table of directed ops, two
// multi-cycle sequences (enable low, reset mid-request) and randomized ops
// scored against an arithmetic model of the access rules.
module tb_load_store_unit;
   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        reset, enable, op_valid, op_load, op_unsigned;
   logic [1:0]  op_size;
   logic [31:0] op_addr, op_wdata;
   logic        op_ready, stall, res_valid, res_error;
   logic [31:0] res_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int pass_cnt = 0;
   int total_cnt = 0;

   load_store_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .enable(enable), .op_valid(op_valid),
      .op_load(op_load), .op_size(op_size), .op_unsigned(op_unsigned),
      .op_addr(op_addr), .op_wdata(op_wdata), .op_ready(op_ready),
      .stall(stall), .res_valid(res_valid), .res_rdata(res_rdata),
      .res_error(res_error), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic [31:0] rd;
      int          lat;
      int          nreq;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wd;
      logic        stable;
      logic        stall_ok;
   } res_t;

   typedef struct packed {
      logic        ld;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          d;
      logic        e_err;
      int          e_lat;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic [31:0] e_rd;
      logic        chk_rd;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Present one op, answer with ack after d wait cycles, collect the outcome.
   task automatic do_op(input logic ld, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int d,
                        input logic en_after, output res_t r);
      logic got;
      got = 1'b0;
      r = '0;
      r.stable = 1'b1;
      r.stall_ok = 1'b1;
      op_load = ld; op_size = sz; op_unsigned = uns;
      op_addr = addr; op_wdata = wdata;
      op_valid = 1'b1; enable = 1'b1; mem_ack = 1'b0;
      @(posedge clk); #1;
      op_valid = 1'b0; op_addr = $urandom(); op_wdata = $urandom();
      op_load = ~ld; op_unsigned = ~uns;
      enable = en_after;
      for (int k = 1; k <= 40; k++) begin
         if (stall !== mem_req) r.stall_ok = 1'b0;
         if (res_valid) begin
            r.lat = k; r.err = res_error; r.rd = res_rdata;
            got = 1'b1;
            break;
         end
         if (mem_req) begin
            r.nreq++;
            if (r.nreq == 1) begin
               r.addr = mem_addr; r.be = mem_be; r.we = mem_we; r.wd = mem_wdata;
            end else if (mem_addr !== r.addr || mem_be !== r.be ||
                         mem_we !== r.we || mem_wdata !== r.wd) begin
               r.stable = 1'b0;
            end
         end
         if (mem_req && r.nreq == d + 1) begin
            mem_ack = 1'b1; mem_rdata = rdata;
         end else begin
            mem_ack = 1'b0; mem_rdata = ~rdata;
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b0; enable = 1'b1;
      if (!got) chk("res_valid_bound", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   // Access rules expressed with plain arithmetic on byte counts and offsets.
   task automatic model(input logic ld, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int d,
                        output logic err, output int lat, output logic [3:0] be,
                        output logic [31:0] wd, output logic [31:0] rd);
      int nb, off;
      logic timed;
      logic [31:0] mask, lane;
      nb  = 1 << sz;
      off = int'(addr % 4);
      err = (sz == 2'd3) || (addr % nb != 0);
      timed = !err && (TO > 0) && (d >= TO);
      lat = err ? 1 : (timed ? TO + 1 : d + 2);
      err = err | timed;
      mask = (nb >= 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
      be = 4'(((1 << nb) - 1) << off);
      wd = (wdata & mask) * ((nb == 1) ? 32'h0101_0101 : (nb == 2) ? 32'h0001_0001 : 32'h1);
      lane = (rdata >> (8 * off)) & mask;
      if (!uns && nb < 4 && lane[8 * nb - 1]) lane = lane | ~mask;
      rd = err ? 32'h0 : lane;
      if (!ld) rd = 32'h0;
   endtask

   function automatic vec_t mk(logic ld, logic [1:0] sz, logic uns, logic [31:0] addr,
                               logic [31:0] wdata, logic [31:0] rdata, int d,
                               logic e_err, int e_lat, logic [3:0] e_be,
                               logic [31:0] e_wd, logic [31:0] e_rd, logic chk_rd);
      vec_t v;
      v.ld = ld; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.d = d; v.e_err = e_err; v.e_lat = e_lat; v.e_be = e_be;
      v.e_wd = e_wd; v.e_rd = e_rd; v.chk_rd = chk_rd;
      return v;
   endfunction

   vec_t tbl [15];

   initial begin
      res_t r;
      logic        m_err;
      int          m_lat;
      logic [3:0]  m_be;
      logic [31:0] m_wd, m_rd;
      logic        seen;

      //               ld   sz    uns  addr          wdata          rdata          d   err  lat be       wdata          rdata          chk
      tbl[0]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0,  1'b0, 2, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b1);
      tbl[1]  = mk(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h1234_56A5, 32'h0,         1,  1'b0, 3, 4'b1000, 32'hA5A5_A5A5, 32'h0,         1'b1);
      tbl[2]  = mk(1'b1, 2'd0, 1'b0, 32'h0000_0102, 32'h0,         32'h1280_4567, 0,  1'b0, 2, 4'b0100, 32'h0,         32'hFFFF_FF80, 1'b1);
      tbl[3]  = mk(1'b1, 2'd0, 1'b1, 32'h0000_0102, 32'h0,         32'h1280_4567, 0,  1'b0, 2, 4'b0100, 32'h0,         32'h0000_0080, 1'b1);
      tbl[4]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h0,         32'h1280_4567, 2,  1'b0, 4, 4'b1100, 32'h0,         32'h0000_1280, 1'b1);
      tbl[5]  = mk(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_BEEF, 32'h0,         0,  1'b0, 2, 4'b1100, 32'hBEEF_BEEF, 32'h0000_1280, 1'b1);
      tbl[6]  = mk(1'b1, 2'd2, 1'b0, 32'h0000_0101, 32'h0,         32'h0,         0,  1'b1, 1, 4'b0000, 32'h0,         32'h0,         1'b1);
      tbl[7]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_F00D, 0,  1'b0, 2, 4'b0011, 32'h0,         32'hFFFF_F00D, 1'b1);
      tbl[8]  = mk(1'b1, 2'd3, 1'b0, 32'h0000_0100, 32'h0,         32'h0,         0,  1'b1, 1, 4'b0000, 32'h0,         32'h0,         1'b1);
      tbl[9]  = mk(1'b1, 2'd2, 1'b0, 32'h0000_0104, 32'h0,         32'hCAFE_BABE, 3,  1'b0, 5, 4'b1111, 32'h0,         32'hCAFE_BABE, 1'b1);
      tbl[10] = mk(1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0,         32'h0000_7F00, 0,  1'b0, 2, 4'b0010, 32'h0,         32'h0000_007F, 1'b1);
      tbl[11] = mk(1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'h0,         32'h1111_1111, 99, 1'b1, 16, 4'b1111, 32'h0,        32'h0,         1'b1);
      tbl[12] = mk(1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'h0,         32'h89AB_CDEF, 14, 1'b0, 16, 4'b1111, 32'h0,        32'h89AB_CDEF, 1'b1);
      tbl[13] = mk(1'b1, 2'd1, 1'b1, 32'h0000_0106, 32'h0,         32'h8001_0000, 0,  1'b0, 2, 4'b1100, 32'h0,         32'h0000_8001, 1'b1);
      tbl[14] = mk(1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h5555_5555, 32'h0,         0,  1'b1, 1, 4'b0000, 32'h0,         32'h0,         1'b0);

      reset = 1'b0; enable = 1'b0; op_valid = 1'b0; op_load = 1'b0; op_size = 2'd0;
      op_unsigned = 1'b0; op_addr = '0; op_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_rdata", res_rdata, 32'h0);
      chk("rst_res_error", 32'(res_error), 32'd0);
      chk("rst_op_ready", 32'(op_ready), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;

      // Directed table
      foreach (tbl[i]) begin
         chk($sformatf("t%0d_op_ready", i), 32'(op_ready), 32'd1);
         do_op(tbl[i].ld, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
               tbl[i].rdata, tbl[i].d, 1'b1, r);
         chk($sformatf("t%0d_err", i), 32'(r.err), 32'(tbl[i].e_err));
         chk($sformatf("t%0d_lat", i), 32'(r.lat), 32'(tbl[i].e_lat));
         chk($sformatf("t%0d_nreq", i), 32'(r.nreq), 32'(tbl[i].e_lat - 1));
         chk($sformatf("t%0d_stall", i), 32'(r.stall_ok), 32'd1);
         if (!tbl[i].e_err) begin
            chk($sformatf("t%0d_addr", i), r.addr, {tbl[i].addr[31:2], 2'b00});
            chk($sformatf("t%0d_be", i), 32'(r.be), 32'(tbl[i].e_be));
            chk($sformatf("t%0d_we", i), 32'(r.we), 32'(!tbl[i].ld));
            chk($sformatf("t%0d_stable", i), 32'(r.stable), 32'd1);
            if (!tbl[i].ld) chk($sformatf("t%0d_wdata", i), r.wd, tbl[i].e_wd);
         end
         if (tbl[i].chk_rd) chk($sformatf("t%0d_rdata", i), r.rd, tbl[i].e_rd);
      end

      // enable low: no acceptance, no stall; enable high: stall while waiting
      op_valid = 1'b1; enable = 1'b0; op_load = 1'b1; op_size = 2'd2; op_addr = 32'h400;
      #1;
      chk("en0_stall", 32'(stall), 32'd0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (mem_req || res_valid) seen = 1'b1;
      end
      chk("en0_no_req", 32'(seen), 32'd0);
      op_valid = 1'b0;
      #1;
      chk("idle_stall", 32'(stall), 32'd0);
      enable = 1'b1; op_valid = 1'b1;
      #1;
      chk("accept_stall", 32'(stall), 32'd1);

      // Reset asserted while a request waits for ack
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("mid_req_high", 32'(mem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst_mem_req", 32'(mem_req), 32'd0);
      chk("arst_outputs", {mem_addr | mem_wdata | res_rdata},  32'h0);
      chk("arst_ctl", {27'd0, mem_we, res_valid, res_error, mem_be[0] | mem_be[1], mem_be[2] | mem_be[3]}, 32'h0);
      chk("arst_stall", 32'(stall), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         if (res_valid || mem_req) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("ack_after_rst_ignored", 32'(seen), 32'd0);

      // Randomized ops against the model
      for (int n = 0; n < 40; n++) begin
         logic        ld, uns, en_a;
         logic [1:0]  sz;
         logic [31:0] a, wd, rd;
         int          d;
         ld  = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         en_a = 1'($urandom_range(0, 1));
         sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a   = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 3));
         else if (sz != 2'd3) a = a | (32'($urandom_range(0, 3)) & ~((32'h1 << sz) - 32'h1) & 32'h3);
         wd  = $urandom();
         rd  = $urandom();
         d   = ($urandom_range(0, 11) == 0) ? TO + 3 : int'($urandom_range(0, 3));
         do_op(ld, sz, uns, a, wd, rd, d, en_a, r);
         model(ld, sz, uns, a, wd, rd, d, m_err, m_lat, m_be, m_wd, m_rd);
         chk($sformatf("r%0d_err", n), 32'(r.err), 32'(m_err));
         chk($sformatf("r%0d_lat", n), 32'(r.lat), 32'(m_lat));
         chk($sformatf("r%0d_stall", n), 32'(r.stall_ok), 32'd1);
         if (r.lat == m_lat && m_lat > 1) begin
            chk($sformatf("r%0d_addr", n), r.addr, {a[31:2], 2'b00});
            chk($sformatf("r%0d_be", n), 32'(r.be), 32'(m_be));
            chk($sformatf("r%0d_we", n), 32'(r.we), 32'(!ld));
            chk($sformatf("r%0d_stable", n), 32'(r.stable), 32'd1);
            if (!ld) chk($sformatf("r%0d_wdata", n), r.wd, m_wd);
         end
         if (ld) chk($sformatf("r%0d_rdata", n), r.rd, m_rd);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
